// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for one data-RAM port: zero-latency command mux, round-robin
// grants locked across stalls, in-order read-response routing via an ID FIFO.
// Define DMEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed r0-first priority.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W  = 15,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic                             clk,
   input  logic                             rstf,
   input  logic                             r0_cmd_valid,
   output logic                             r0_cmd_ready,
   input  logic                             r0_cmd_we,
   input  logic [ADDR_W-1:0]                r0_cmd_addr,
   input  logic [31:0]                      r0_cmd_data,
   input  logic [3:0]                       r0_cmd_mask,
   output logic                             r0_rsp_valid,
   output logic [31:0]                      r0_rsp_data,
   input  logic                             r1_cmd_valid,
   output logic                             r1_cmd_ready,
   input  logic                             r1_cmd_we,
   input  logic [ADDR_W-1:0]                r1_cmd_addr,
   input  logic [31:0]                      r1_cmd_data,
   input  logic [3:0]                       r1_cmd_mask,
   output logic                             r1_rsp_valid,
   output logic [31:0]                      r1_rsp_data,
   output logic                             m_cmd_valid,
   input  logic                             m_cmd_ready,
   output logic                             m_cmd_we,
   output logic [ADDR_W-1:0]                m_cmd_addr,
   output logic [31:0]                      m_cmd_data,
   output logic [3:0]                       m_cmd_mask,
   input  logic                             m_rsp_valid,
   input  logic [31:0]                      m_rsp_data,
   output logic                             err_orphan,
   output logic [$clog2(MAX_OUT+1)-1:0]     outstanding
);

   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
   localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [MAX_OUT-1:0] id_mem_q, id_mem_d;
   logic               lock_q, lock_d, lock_sel_q, lock_sel_d;
   logic               err_q, err_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
   logic               rr_q, rr_d;
`endif

   logic full, elig0, elig1, cand0, cand1;
   logic sel, sel_elig, hs, push, pop, head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Reads are held off while every ID slot is in use; writes never need a slot.
   assign full  = (cnt_q == CNT_W'(MAX_OUT));
   assign elig0 = r0_cmd_we | ~full;
   assign elig1 = r1_cmd_we | ~full;
   assign cand0 = r0_cmd_valid & elig0;
   assign cand1 = r1_cmd_valid & elig1;

   always_comb begin
      sel = cand1;
      if (lock_q) begin
         sel = lock_sel_q;
      end else if (cand0 & cand1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         sel = 1'b0;
`else
         sel = rr_q;
`endif
      end
   end

   assign sel_elig     = sel ? elig1 : elig0;
   assign m_cmd_valid  = (sel ? r1_cmd_valid : r0_cmd_valid) & sel_elig;
   assign m_cmd_we     = sel ? r1_cmd_we   : r0_cmd_we;
   assign m_cmd_addr   = sel ? r1_cmd_addr : r0_cmd_addr;
   assign m_cmd_data   = sel ? r1_cmd_data : r0_cmd_data;
   assign m_cmd_mask   = sel ? r1_cmd_mask : r0_cmd_mask;
   assign r0_cmd_ready = m_cmd_ready & ~sel & sel_elig;
   assign r1_cmd_ready = m_cmd_ready &  sel & sel_elig;

   assign hs   = m_cmd_valid & m_cmd_ready;
   assign push = hs & ~m_cmd_we;
   assign pop  = m_rsp_valid & (cnt_q != '0);
   assign head = id_mem_q[rd_ptr_q];

   assign r0_rsp_valid = pop & ~head;
   assign r1_rsp_valid = pop &  head;
   assign r0_rsp_data  = m_rsp_data;
   assign r1_rsp_data  = m_rsp_data;
   assign err_orphan   = err_q;
   assign outstanding  = cnt_q;

   // Next-state: lock, rr pointer, ID FIFO and the sticky orphan flag.
   always_comb begin
      lock_d     = m_cmd_valid & ~m_cmd_ready;
      lock_sel_d = sel;
      err_d      = err_q | (m_rsp_valid & (cnt_q == '0));
      id_mem_d   = id_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      rr_d       = hs ? ~sel : rr_q;
`endif
      if (push) begin
         id_mem_d[wr_ptr_q] = sel;
         wr_ptr_d           = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         id_mem_q   <= '0;
         lock_q     <= 1'b0;
         lock_sel_q <= 1'b0;
         err_q      <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         rr_q       <= 1'b0;
`endif
      end else begin
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         id_mem_q   <= id_mem_d;
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
         err_q      <= err_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         rr_q       <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic, all checked
// cycle-by-cycle against a queue-based reference model of the arbitration rules.
module tb_dmem_port_arbiter;

   localparam int unsigned ADDR_W  = 15;
   localparam int unsigned MAX_OUT = 4;
   localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);
`ifdef DMEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstf;
   logic r0_cmd_valid, r0_cmd_ready, r0_cmd_we, r0_rsp_valid;
   logic r1_cmd_valid, r1_cmd_ready, r1_cmd_we, r1_rsp_valid;
   logic [ADDR_W-1:0] r0_cmd_addr, r1_cmd_addr, m_cmd_addr;
   logic [31:0] r0_cmd_data, r1_cmd_data, m_cmd_data, r0_rsp_data, r1_rsp_data, m_rsp_data;
   logic [3:0] r0_cmd_mask, r1_cmd_mask, m_cmd_mask;
   logic m_cmd_valid, m_cmd_ready, m_cmd_we, m_rsp_valid, err_orphan;
   logic [CNT_W-1:0] outstanding;

   dmem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rstf(rstf),
      .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready), .r0_cmd_we(r0_cmd_we),
      .r0_cmd_addr(r0_cmd_addr), .r0_cmd_data(r0_cmd_data), .r0_cmd_mask(r0_cmd_mask),
      .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data),
      .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready), .r1_cmd_we(r1_cmd_we),
      .r1_cmd_addr(r1_cmd_addr), .r1_cmd_data(r1_cmd_data), .r1_cmd_mask(r1_cmd_mask),
      .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data),
      .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_we(m_cmd_we),
      .m_cmd_addr(m_cmd_addr), .m_cmd_data(m_cmd_data), .m_cmd_mask(m_cmd_mask),
      .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
      .err_orphan(err_orphan), .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of requester IDs awaiting read data, plus grant state.
   int q[$];
   bit m_locked, m_err;
   int m_held, m_pref;
   int e_sel;
   bit e_mv, e_we;
   bit acc[2];
   bit hold[2];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_locked = 1'b0;
      m_err    = 1'b0;
      m_held   = 0;
      m_pref   = 0;
   endfunction

   task automatic set_req(input int n, input bit v, input bit we, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] m);
      if (n == 0) begin
         r0_cmd_valid = v; r0_cmd_we = we; r0_cmd_addr = a; r0_cmd_data = d; r0_cmd_mask = m;
      end else begin
         r1_cmd_valid = v; r1_cmd_we = we; r1_cmd_addr = a; r1_cmd_data = d; r1_cmd_mask = m;
      end
   endtask

   // Let inputs settle, then compare every observable output with the model.
   task automatic settle();
      bit v[2], we[2], elig[2], cand[2];
      bit have;
      int head;
      if (!rstf) model_reset();
      #1;
      v[0] = r0_cmd_valid; v[1] = r1_cmd_valid;
      we[0] = r0_cmd_we;   we[1] = r1_cmd_we;
      for (int n = 0; n < 2; n++) begin
         elig[n] = we[n] || (q.size() < MAX_OUT);
         cand[n] = v[n] && elig[n];
      end
      if (m_locked)                e_sel = m_held;
      else if (cand[0] && cand[1]) e_sel = FIXED ? 0 : m_pref;
      else                         e_sel = cand[1] ? 1 : 0;
      e_mv = v[e_sel] && elig[e_sel];
      e_we = we[e_sel];
      chk("m_cmd_valid", 64'(m_cmd_valid), 64'(e_mv));
      if (e_mv) begin
         chk("m_cmd_we", 64'(m_cmd_we), 64'(e_we));
         chk("m_cmd_addr", 64'(m_cmd_addr), 64'(e_sel == 1 ? r1_cmd_addr : r0_cmd_addr));
         chk("m_cmd_data", 64'(m_cmd_data), 64'(e_sel == 1 ? r1_cmd_data : r0_cmd_data));
         chk("m_cmd_mask", 64'(m_cmd_mask), 64'(e_sel == 1 ? r1_cmd_mask : r0_cmd_mask));
      end
      if (v[0]) chk("r0_cmd_ready", 64'(r0_cmd_ready), 64'(m_cmd_ready && e_sel == 0 && elig[0]));
      if (v[1]) chk("r1_cmd_ready", 64'(r1_cmd_ready), 64'(m_cmd_ready && e_sel == 1 && elig[1]));
      have = m_rsp_valid && (q.size() > 0);
      head = (q.size() > 0) ? q[0] : 0;
      chk("r0_rsp_valid", 64'(r0_rsp_valid), 64'(have && head == 0));
      chk("r1_rsp_valid", 64'(r1_rsp_valid), 64'(have && head == 1));
      if (have) chk("rsp_data", 64'(head == 1 ? r1_rsp_data : r0_rsp_data), 64'(m_rsp_data));
      chk("outstanding", 64'(outstanding), 64'(q.size()));
      chk("err_orphan", 64'(err_orphan), 64'(m_err));
   endtask

   // Advance the model across the clock edge, then return to the falling edge.
   task automatic tick();
      bit a;
      @(posedge clk);
      acc[0] = 1'b0; acc[1] = 1'b0;
      if (rstf) begin
         a = e_mv && m_cmd_ready;
         if (m_rsp_valid) begin
            if (q.size() == 0) m_err = 1'b1;
            else void'(q.pop_front());
         end
         if (a && !e_we) q.push_back(e_sel);
         if (a) m_pref = 1 - e_sel;
         acc[e_sel] = a;
         m_locked = e_mv && !m_cmd_ready;
         m_held   = e_sel;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      set_req(0, 1'b0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0, '0);
      m_cmd_ready = 1'b0;
      m_rsp_valid = 1'b0;
      m_rsp_data  = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rstf = 1'b0;
      settle();
      tick();
      rstf = 1'b1;
   endtask

   task automatic drain();
      idle_inputs();
      for (int i = 0; i < MAX_OUT + 2; i++) begin
         m_rsp_valid = (q.size() > 0);
         m_rsp_data  = $urandom;
         settle();
         tick();
      end
      m_rsp_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] rsp_tbl [3];
      rsp_tbl[0] = 32'hA; rsp_tbl[1] = 32'hB; rsp_tbl[2] = 32'hC;
      idle_inputs();
      rstf = 1'b0;
      @(negedge clk);
      do_reset();

      // single requester read, data two cycles after accept
      set_req(0, 1'b1, 1'b0, ADDR_W'(16'h10), '0, 4'hF);
      m_cmd_ready = 1'b1;
      settle(); chk("t1_ready", 64'(r0_cmd_ready), 64'd1); tick();
      idle_inputs();
      settle(); chk("t1_out1", 64'(outstanding), 64'd1); tick();
      m_rsp_valid = 1'b1; m_rsp_data = 32'hDEADBEEF;
      settle();
      chk("t1_rsp_v", 64'(r0_rsp_valid), 64'd1);
      chk("t1_rsp_d", 64'(r0_rsp_data), 64'hDEADBEEF);
      chk("t1_r1_rsp", 64'(r1_rsp_valid), 64'd0);
      tick();
      idle_inputs();
      settle(); chk("t1_out0", 64'(outstanding), 64'd0); tick();

      // contention: alternating grants (r0 only under fixed priority)
      do_reset();
      for (int k = 0; k < 6; k++) begin
         set_req(0, 1'b1, 1'b0, ADDR_W'(16'h100 + k), 32'(k), 4'hF);
         set_req(1, 1'b1, 1'b0, ADDR_W'(16'h180 + k), 32'(k), 4'hF);
         m_cmd_ready = 1'b1;
         m_rsp_valid = (q.size() > 0);
         m_rsp_data  = $urandom;
         settle();
         chk("t2_grant_r1", 64'(r1_cmd_ready), 64'(FIXED ? 0 : (k % 2)));
         chk("t2_grant_r0", 64'(r0_cmd_ready), 64'(FIXED ? 1 : 1 - (k % 2)));
         tick();
      end
      drain();

      // stall lock holds r1 while r0 shows up
      do_reset();
      set_req(1, 1'b1, 1'b0, ADDR_W'(16'h200), 32'h11, 4'hF);
      for (int k = 0; k < 3; k++) begin
         if (k >= 1) set_req(0, 1'b1, 1'b0, ADDR_W'(16'h300), 32'h22, 4'hF);
         settle();
         chk("t3_addr", 64'(m_cmd_addr), 64'h200);
         chk("t3_r0_rdy", 64'(r0_cmd_ready), 64'd0);
         tick();
      end
      m_cmd_ready = 1'b1;
      settle(); chk("t3_r1_hs", 64'(r1_cmd_ready), 64'd1); chk("t3_r0_hs", 64'(r0_cmd_ready), 64'd0); tick();
      set_req(1, 1'b0, 1'b0, '0, '0, '0);
      settle(); tick();
      drain();

      // FIFO full blocks reads but not writes; same-cycle pop does not unblock
      do_reset();
      m_cmd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_req(0, 1'b1, 1'b0, ADDR_W'(16'h400 + 4 * k), '0, 4'hF);
         settle(); tick();
      end
      set_req(0, 1'b1, 1'b0, ADDR_W'(16'h500), '0, 4'hF);
      set_req(1, 1'b1, 1'b1, ADDR_W'(16'h600), 32'hCAFE, 4'h3);
      settle();
      chk("t4_full", 64'(outstanding), 64'd4);
      chk("t4_r0_blk", 64'(r0_cmd_ready), 64'd0);
      chk("t4_r1_wr", 64'(r1_cmd_ready), 64'd1);
      tick();
      set_req(1, 1'b0, 1'b0, '0, '0, '0);
      m_rsp_valid = 1'b1; m_rsp_data = 32'h1234;
      settle(); chk("t4_pop_same", 64'(r0_cmd_ready), 64'd0); tick();
      m_rsp_valid = 1'b0;
      settle(); chk("t4_unblk", 64'(r0_cmd_ready), 64'd1); tick();
      drain();

      // interleaved routing r0,r1,r0
      do_reset();
      m_cmd_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_req(k % 2, 1'b1, 1'b0, ADDR_W'(16'h700 + k), '0, 4'hF);
         settle(); tick();
         set_req(k % 2, 1'b0, 1'b0, '0, '0, '0);
      end
      for (int k = 0; k < 3; k++) begin
         m_rsp_valid = 1'b1; m_rsp_data = rsp_tbl[k];
         settle();
         chk("t5_rsp_v", 64'(k % 2 == 1 ? r1_rsp_valid : r0_rsp_valid), 64'd1);
         chk("t5_rsp_d", 64'(k % 2 == 1 ? r1_rsp_data : r0_rsp_data), 64'(rsp_tbl[k]));
         tick();
      end
      idle_inputs();

      // reset with reads in flight, then an orphan response
      do_reset();
      m_cmd_ready = 1'b1;
      set_req(0, 1'b1, 1'b0, ADDR_W'(16'h800), '0, 4'hF); settle(); tick();
      set_req(0, 1'b0, 1'b0, '0, '0, '0);
      set_req(1, 1'b1, 1'b0, ADDR_W'(16'h804), '0, 4'hF); settle(); tick();
      idle_inputs();
      rstf = 1'b0;
      settle(); chk("t6_rst_out", 64'(outstanding), 64'd0); tick();
      rstf = 1'b1;
      m_rsp_valid = 1'b1; m_rsp_data = 32'h55;
      settle(); chk("t6_drop0", 64'(r0_rsp_valid), 64'd0); chk("t6_drop1", 64'(r1_rsp_valid), 64'd0); tick();
      m_rsp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin settle(); tick(); end
      settle(); chk("t6_err", 64'(err_orphan), 64'd1); chk("t6_out", 64'(outstanding), 64'd0); tick();

      // random traffic with requesters holding stalled commands
      do_reset();
      hold[0] = 1'b0; hold[1] = 1'b0;
      for (int i = 0; i < 800; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (!hold[n])
               set_req(n, 1'($urandom), 1'($urandom), ADDR_W'($urandom), $urandom, 4'($urandom));
         end
         m_cmd_ready = ($urandom % 4) != 0;
         m_rsp_valid = (q.size() > 0) && (($urandom % 3) == 0);
         m_rsp_data  = $urandom;
         settle();
         tick();
         hold[0] = r0_cmd_valid && !acc[0];
         hold[1] = r1_cmd_valid && !acc[1];
      end
      drain();
      do_reset();
      settle(); chk("final_err_clr", 64'(err_orphan), 64'd0); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Two-requester arbiter that shares one port of the byte-addressable dual-port data RAM.
- Requester 0 is the CPU data bus. Requester 1 is a loader/DMA master.
- Commands pass through with zero added latency. Grants are round-robin and locked while a command is stalled.
- Read responses return in order and are routed back to the issuing requester through an outstanding-ID FIFO.

Parameters:
ADDR_W, 15, byte address width presented to the RAM port (log2(DEPTH)+2 for DEPTH=8192)
MAX_OUT, 4, maximum outstanding reads (ID FIFO depth); must be >= 1

Ports:
clk  input  1  clock
rstf  input  1  asynchronous active-low reset
rN_cmd_valid  input  1  N in {0,1}: requester command valid
rN_cmd_ready  output  1  command accepted when valid & ready
rN_cmd_we  input  1  1 = write, 0 = read
rN_cmd_addr  input  ADDR_W  byte address
rN_cmd_data  input  32  write data
rN_cmd_mask  input  4  byte enables
rN_rsp_valid  output  1  read data valid (single-cycle pulse, no backpressure)
rN_rsp_data  output  32  read data
m_cmd_valid  output  1  command to RAM port
m_cmd_ready  input  1  RAM accepts command
m_cmd_we / m_cmd_addr / m_cmd_data / m_cmd_mask  output  1/ADDR_W/32/4  muxed command fields
m_rsp_valid  input  1  RAM read response valid (reads only, in order)
m_rsp_data  input  32  RAM read data
err_orphan  output  1  sticky: m_rsp_valid seen with empty ID FIFO
outstanding  output  $clog2(MAX_OUT+1)  current FIFO occupancy

Behaviour:
- Reset values: rr pointer = r0 preferred; lock clear; FIFO empty; outstanding = 0; err_orphan = 0; all rN_rsp_valid = 0.
- Reset mid-operation: everything above is cleared immediately. In-flight RAM responses that arrive after reset have no FIFO entry, so they are dropped and set err_orphan.
- Blocking: a requester presenting a read is blocked while the FIFO is full (outstanding == MAX_OUT). A pop in the same cycle does not unblock it. Writes are never blocked by the FIFO.
- Selection, when unlocked: among eligible valid requesters, pick the rr-preferred one; otherwise pick the only eligible one.
- m_cmd_* are a combinational mux of the selected requester. m_cmd_valid = selected valid & eligible.
- rN_cmd_ready = m_cmd_ready & (selected == N) & eligible. The unselected requester sees ready = 0.
- Lock: if m_cmd_valid & !m_cmd_ready, register lock = 1 and hold the selected index. The held index is used while locked, which keeps m_cmd_* stable. The lock releases on the handshake cycle.
- On each accepted handshake, the rr pointer moves to prefer the other requester.
- FIFO push: accepted read pushes the 1-bit requester ID.
- FIFO pop: m_rsp_valid pops the head. Combinationally, rH_rsp_valid = 1 and rH_rsp_data = m_rsp_data, where H is the head ID. The other requester sees rsp_valid = 0.
- Push and pop in the same cycle: allowed when not full; occupancy is unchanged.
- m_rsp_valid while the FIFO is empty: response dropped, err_orphan set (sticky until reset).
- rN_rsp_data may carry m_rsp_data unconditionally; only rN_rsp_valid is gated.
- outstanding is registered and tracks FIFO occupancy exactly.

Optional Feature:
- DMEM_ARB_FIXED_PRIO_EN defined: the rr pointer is removed and r0 (CPU) always wins when both are eligible and the arbiter is unlocked. The lock and FIFO rules are unchanged, so r1 can be starved.
- Not defined: round-robin as described in Behaviour.

Test Plan:
- Single requester: r0 read addr 0x10, m_cmd_ready=1, RAM returns 0xDEADBEEF two cycles later -> r0_cmd_ready pulses once; r0_rsp_valid=1 with 0xDEADBEEF; r1_rsp_valid stays 0; outstanding goes 0->1->0.
- Contention: r0 and r1 both issue reads back-to-back, m_cmd_ready=1, 6 commands -> grants alternate r0,r1,r0,r1,r0,r1. With FIXED_PRIO_EN -> all grants go to r0 while r0 is valid.
- Stall lock: r1 is granted with m_cmd_ready=0 for 3 cycles while r0 becomes valid -> m_cmd_addr equals r1's address and is stable all 3 cycles; r0_cmd_ready=0; r1 handshakes on ready.
- FIFO full, MAX_OUT=4: 4 reads accepted with no responses -> 5th read sees ready=0. A write from the other requester is accepted meanwhile. One response -> the read is accepted the next cycle.
- Interleaved routing: issue reads r0,r1,r0, responses 0xA,0xB,0xC -> r0 gets 0xA, r1 gets 0xB, r0 gets 0xC.
- Orphan/reset: drop rstf during 2 outstanding reads, then deliver 1 response -> FIFO empty, response dropped, err_orphan=1 and held until the next reset.
